// File: rtl/seq_ctrl_pkg.sv
// Shared encodings and widths for the counter sequencer.
package seq_ctrl_pkg;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned NIB_W = 4;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_HOLD = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Count-step prescaler: one tick every PRESCALE cycles of RUN, frozen in HOLD, cleared elsewhere.
module tick_prescaler #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic run,
   input  logic hold,
   output logic tick
);

   localparam int unsigned PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
      end else if (!hold) begin
         cnt <= '0;
      end
   end

   // Tick lands on the PRESCALE-th RUN cycle.
   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the cascaded 8-bit up/down counter pair (load, run to terminal, stop or reload).
// Optional prescaled stepping is enabled with the PRESCALE_EN macro.
module counter_seq_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int unsigned PRESCALE = 4,
   parameter int unsigned WRAP_W   = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              mode,
   input  logic              dir,
   input  logic [CNT_W-1:0]  load_val,
   input  logic [CNT_W-1:0]  term_val,
   input  logic [CNT_W-1:0]  cnt_q,
   output logic              cnt_en,
   output logic              cnt_load,
   output logic              cnt_up,
   output logic              cnt_clr,
   output logic [NIB_W-1:0]  cnt_d1,
   output logic [NIB_W-1:0]  cnt_d2,
   output logic              busy,
   output logic              done,
   output logic [WRAP_W-1:0] wrap_cnt
);

   state_t              state, state_n;
   logic [CNT_W-1:0]    lv, tv;
   logic                dir_r, mode_r;
   logic                done_n, capture;
   logic [WRAP_W-1:0]   wrap_n;
   logic                hit, tick, step;

   assign hit = (cnt_q == tv);

`ifdef PRESCALE_EN
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .clr  (clr),
      .run  (state == S_RUN),
      .hold (state == S_HOLD),
      .tick (tick)
   );
`else
   logic [31:0] prescale_unused;
   assign prescale_unused = 32'(PRESCALE);
   assign tick = 1'b1;
`endif

   // Datapath control decode.
   assign step     = (state == S_RUN) && !hit && !stop && !clr && tick;
   assign cnt_clr  = clr | stop;
   assign cnt_load = (state == S_LOAD) && !stop;
   assign cnt_en   = cnt_load | step;
   assign cnt_up   = dir_r;
   assign cnt_d1   = lv[NIB_W-1:0];
   assign cnt_d2   = lv[CNT_W-1:NIB_W];
   assign busy     = (state == S_LOAD) || (state == S_RUN) || (state == S_HOLD);

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= S_IDLE;
         lv       <= '0;
         tv       <= '0;
         dir_r    <= 1'b0;
         mode_r   <= 1'b0;
         done     <= 1'b0;
         wrap_cnt <= '0;
      end else begin
         state    <= state_n;
         done     <= done_n;
         wrap_cnt <= wrap_n;
         if (capture) begin
            lv     <= load_val;
            tv     <= term_val;
            dir_r  <= dir;
            mode_r <= mode;
         end
      end
   end

   // Next state: stop > terminal hit > start > pause.
   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      wrap_n  = wrap_cnt;
      capture = 1'b0;
      if (stop) begin
         state_n = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_n = S_LOAD;
                  wrap_n  = '0;
                  capture = 1'b1;
               end
            end
            S_LOAD: state_n = S_RUN;
            S_RUN: begin
               if (hit) begin
                  done_n = 1'b1;
                  if (mode_r == MODE_ONESHOT) begin
                     state_n = S_DONE;
                  end else begin
                     state_n = S_LOAD;
                     wrap_n  = (&wrap_cnt) ? wrap_cnt : wrap_cnt + WRAP_W'(1);
                  end
               end else if (pause) begin
                  state_n = S_HOLD;
               end
            end
            S_HOLD: begin
               if (!pause) state_n = S_RUN;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 8-bit counter pair closing the loop.
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       clr = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
   logic       mode = 1'b0, dir = 1'b0;
   logic [7:0] load_val = '0, term_val = '0;
   logic [7:0] cnt_q;
   logic       cnt_en, cnt_load, cnt_up, cnt_clr, busy, done;
   logic [3:0] cnt_d1, cnt_d2;
   logic [7:0] wrap_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int edges;

   always #5 clk = ~clk;

   counter_seq_ctrl #(
      .PRESCALE (4),
      .WRAP_W   (8)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .mode     (mode),
      .dir      (dir),
      .load_val (load_val),
      .term_val (term_val),
      .cnt_q    (cnt_q),
      .cnt_en   (cnt_en),
      .cnt_load (cnt_load),
      .cnt_up   (cnt_up),
      .cnt_clr  (cnt_clr),
      .cnt_d1   (cnt_d1),
      .cnt_d2   (cnt_d2),
      .busy     (busy),
      .done     (done),
      .wrap_cnt (wrap_cnt)
   );

   // Cascaded nibble counter pair: clear > load > count.
   always @(posedge clk) begin
      if (cnt_clr)
         cnt_q <= 8'h00;
      else if (cnt_en)
         cnt_q <= cnt_load ? {cnt_d2, cnt_d1} : (cnt_up ? cnt_q + 8'd1 : cnt_q - 8'd1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] l, input logic [7:0] t, input logic d, input logic m);
      load_val = l;
      term_val = t;
      dir      = d;
      mode     = m;
      start    = 1'b1;
      step_edge();
      start    = 1'b0;
   endtask

   // Edges counted after the current point until done is seen (bounded).
   task automatic wait_done(output int n);
      n = 0;
      do begin
         step_edge();
         n++;
      end while (!done && n < 60);
   endtask

   initial begin
      // Reset
      clr = 1'b1;
      #1;
      check("rst_cnt_clr", 32'(cnt_clr), 32'd1);
      step_edge();
      step_edge();
      check("rst_cnt_en", 32'(cnt_en), 32'd0);
      clr = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wrap", 32'(wrap_cnt), 32'd0);
      check("rst_lv", 32'({cnt_d2, cnt_d1}), 32'h00);
      check("rst_up", 32'(cnt_up), 32'd0);
      check("rst_cnt_q", 32'(cnt_q), 32'h00);

`ifndef PRESCALE_EN
      // 1: one-shot up 10 -> 15
      pulse_start(8'h10, 8'h15, 1'b1, 1'b0);
      check("t1_busy_load", 32'(busy), 32'd1);
      check("t1_cnt_load", 32'(cnt_load), 32'd1);
      check("t1_cnt_en", 32'(cnt_en), 32'd1);
      check("t1_lv", 32'({cnt_d2, cnt_d1}), 32'h10);
      check("t1_up", 32'(cnt_up), 32'd1);
      wait_done(edges);
      check("t1_latency", 32'(edges), 32'd7);
      check("t1_cnt_q", 32'(cnt_q), 32'h15);
      check("t1_busy_done", 32'(busy), 32'd0);
      step_edge();
      check("t1_done_pulse", 32'(done), 32'd0);
      check("t1_en_idle", 32'(cnt_en), 32'd0);
      check("t1_q_held", 32'(cnt_q), 32'h15);

      // 2: down through 00 -> FF
      pulse_start(8'h02, 8'hFE, 1'b0, 1'b0);
      for (int e = 1; e <= 6; e++) begin
         logic [7:0] seq [1:5];
         seq = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
         step_edge();
         if (e <= 5) check($sformatf("t2_q_e%0d", e), 32'(cnt_q), 32'(seq[e]));
         check($sformatf("t2_done_e%0d", e), 32'(done), (e == 6) ? 32'd1 : 32'd0);
      end

      // 3: periodic 0 -> 3, period 5
      pulse_start(8'h00, 8'h03, 1'b1, 1'b1);
      check("t3_wrap_cleared", 32'(wrap_cnt), 32'd0);
      for (int p = 1; p <= 3; p++) begin
         wait_done(edges);
         check($sformatf("t3_period_%0d", p), 32'(edges), 32'd5);
         check($sformatf("t3_wrap_%0d", p), 32'(wrap_cnt), 32'(p));
      end
      stop = 1'b1;
      #1;
      check("t3_stop_clr", 32'(cnt_clr), 32'd1);
      check("t3_stop_en", 32'(cnt_en), 32'd0);
      step_edge();
      stop = 1'b0;
      #1;
      check("t3_stop_busy", 32'(busy), 32'd0);
      check("t3_stop_wrap", 32'(wrap_cnt), 32'd3);
      check("t3_stop_q", 32'(cnt_q), 32'h00);

      // 4: pause three cycles mid-run, 0 -> 5
      pulse_start(8'h00, 8'h05, 1'b1, 1'b0);
      edges = 0;
      for (int e = 1; e <= 20; e++) begin
         step_edge();
         if (e == 3) pause = 1'b1;
         if (e == 6) pause = 1'b0;
         if (e == 5 || e == 6) check($sformatf("t4_frozen_e%0d", e), 32'(cnt_q), 32'h03);
         if (done) begin
            edges = e;
            break;
         end
      end
      check("t4_latency", 32'(edges), 32'd10);
      check("t4_cnt_q", 32'(cnt_q), 32'h05);

      // 5: periodic 05 -> 07, start ignored in RUN, clr on the hit cycle
      pulse_start(8'h05, 8'h07, 1'b1, 1'b1);
      for (int e = 1; e <= 7; e++) begin
         step_edge();
         if (e == 4) begin
            check("t5_done", 32'(done), 32'd1);
            check("t5_wrap1", 32'(wrap_cnt), 32'd1);
         end
         if (e == 5) begin
            load_val = 8'hA0;
            start    = 1'b1;
         end
         if (e == 6) begin
            start = 1'b0;
            check("t5_start_ign_q", 32'(cnt_q), 32'h06);
            check("t5_start_ign_busy", 32'(busy), 32'd1);
            check("t5_start_ign_lv", 32'({cnt_d2, cnt_d1}), 32'h05);
         end
      end
      check("t5_q_07", 32'(cnt_q), 32'h07);
      clr = 1'b1;
      #1;
      check("t5_clr_cnt_clr", 32'(cnt_clr), 32'd1);
      check("t5_clr_cnt_en", 32'(cnt_en), 32'd0);
      step_edge();
      clr = 1'b0;
      #1;
      check("t5_clr_busy", 32'(busy), 32'd0);
      check("t5_clr_wrap", 32'(wrap_cnt), 32'd0);
      check("t5_clr_done", 32'(done), 32'd0);
      check("t5_clr_q", 32'(cnt_q), 32'h00);
`else
      // 6: prescaled stepping, 0 -> 2 with PRESCALE=4
      pulse_start(8'h00, 8'h02, 1'b1, 1'b0);
      edges = 0;
      for (int e = 1; e <= 40; e++) begin
         step_edge();
         if (e == 4) check("t6_q_e4", 32'(cnt_q), 32'h00);
         if (e == 5) check("t6_q_e5", 32'(cnt_q), 32'h01);
         if (e == 8) check("t6_q_e8", 32'(cnt_q), 32'h01);
         if (e == 9) check("t6_q_e9", 32'(cnt_q), 32'h02);
         if (done) begin
            edges = e;
            break;
         end
      end
      check("t6_latency", 32'(edges), 32'd10);
`endif

      // Zero distance: lv == tv
      pulse_start(8'h5A, 8'h5A, 1'b0, 1'b0);
      wait_done(edges);
      check("eq_latency", 32'(edges), 32'd2);
      check("eq_cnt_q", 32'(cnt_q), 32'h5A);
      check("eq_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
